// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection sensors/lamps and the phase scheduler.
// The scheduler (slave) samples the queue counts and the emergency level every
// cycle and drives the lamp and debug outputs. The environment (master) does the
// reverse. There is no valid/ready pair: every signal is a level, so a value is
// consumed on each posedge clk and the outputs hold until the scheduler changes state.
interface traffic_phase_scheduler_if;
  logic [2:0] main_num;
  logic [2:0] left_num;
  logic [2:0] sec_num;
  logic [2:0] p_num;
  logic       s_emergency;
  logic [3:0] m_LRYG;
  logic [2:0] s_RYG;
  logic [2:0] p;
  logic [3:0] state_o;

  modport master (
    output main_num, left_num, sec_num, p_num, s_emergency,
    input  m_LRYG, s_RYG, p, state_o
  );

  modport slave (
    input  main_num, left_num, sec_num, p_num, s_emergency,
    output m_LRYG, s_RYG, p, state_o
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Round-robin traffic phase sequencer: MAIN through, MAIN left, SECondary, PEDestrian.
// Greens are sized by live queue counts (min/max green, gap-out); an emergency
// vehicle on the secondary road preempts to secondary green. Lamps are decoded
// from the registered state, so they move in the same cycle as state_o.
module traffic_phase_scheduler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MIN_G    = 5,
  parameter int MAX_G    = 20,
  parameter int YEL_T    = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 6,
  parameter int FLASH_T  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_phase_scheduler_if.slave   bus
);

  typedef enum logic [3:0] {
    ST_ALL_RED   = 4'd0,
    ST_MAIN_G    = 4'd1,
    ST_MAIN_Y    = 4'd2,
    ST_LEFT_G    = 4'd3,
    ST_LEFT_Y    = 4'd4,
    ST_SEC_G     = 4'd5,
    ST_SEC_Y     = 4'd6,
    ST_PED_WALK  = 4'd7,
    ST_PED_FLASH = 4'd8,
    ST_EMERG     = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    PH_MAIN = 2'd0,
    PH_LEFT = 2'd1,
    PH_SEC  = 2'd2,
    PH_PED  = 2'd3
  } phase_e;

  localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [8:0]  MIN_G_9   = 9'(MIN_G);
  localparam logic [8:0]  MAX_G_9   = 9'(MAX_G);

  state_e        state_q, state_d;
  phase_e        ptr_q, ptr_d;
  // Fixed-duration states count down remaining ticks; green states count up elapsed ticks.
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;

  logic          tick;
  logic          emerg;
  logic          other_demand;
  logic [8:0]    g_plus1;
  logic          max_out;
  logic          min_met;
  logic          timer_done;
  logic          go;
  state_e        go_state;
  phase_e        next_phase;

  // Load value of the shared counter when a state is entered.
  function automatic logic [7:0] entry_count(input state_e s);
    case (s)
      ST_MAIN_Y, ST_LEFT_Y, ST_SEC_Y: entry_count = 8'(YEL_T);
      ST_ALL_RED:                     entry_count = 8'(ALLRED_T);
      ST_PED_WALK:                    entry_count = 8'(WALK_T);
      ST_PED_FLASH:                   entry_count = 8'(FLASH_T);
      default:                        entry_count = 8'd0;
    endcase
  endfunction

  // First eligible phase after the rotation pointer; MAIN is always eligible,
  // so the search always terminates with a valid phase.
  function automatic phase_e pick_phase(input phase_e ptr, input logic [2:0] ln,
                                        input logic [2:0] sn, input logic [2:0] pn);
    logic   found;
    phase_e cand;
    found      = 1'b0;
    pick_phase = PH_MAIN;
    for (int k = 1; k <= 4; k++) begin
      cand = phase_e'(2'(ptr + 2'(k)));
      if (!found) begin
        case (cand)
          PH_MAIN: begin found = 1'b1; pick_phase = PH_MAIN; end
          PH_LEFT: if (ln != 3'd0) begin found = 1'b1; pick_phase = PH_LEFT; end
          PH_SEC:  if (sn != 3'd0) begin found = 1'b1; pick_phase = PH_SEC;  end
          default: if (pn != 3'd0) begin found = 1'b1; pick_phase = PH_PED;  end
        endcase
      end
    end
  endfunction

  function automatic state_e green_of(input phase_e ph);
    case (ph)
      PH_MAIN: green_of = ST_MAIN_G;
      PH_LEFT: green_of = ST_LEFT_G;
      PH_SEC:  green_of = ST_SEC_G;
      default: green_of = ST_PED_WALK;
    endcase
  endfunction

  assign tick         = (presc_q == PRESC_MAX);
  assign emerg        = bus.s_emergency;
  assign other_demand = (bus.left_num != 3'd0) || (bus.sec_num != 3'd0) || (bus.p_num != 3'd0);
  assign g_plus1      = {1'b0, cnt_q} + 9'd1;
  assign max_out      = (g_plus1 == MAX_G_9);
  assign min_met      = (g_plus1 >= MIN_G_9);
  assign timer_done   = (cnt_q == 8'd1);
  assign next_phase   = pick_phase(ptr_q, bus.left_num, bus.sec_num, bus.p_num);

  // Next-state, counter, pointer and prescaler computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    presc_d  = tick ? '0 : presc_q + 1'b1;
    go       = 1'b0;
    go_state = state_q;

    case (state_q)
      ST_MAIN_G: begin
        if (emerg) begin
          go = 1'b1; go_state = ST_MAIN_Y;
        end else if (tick) begin
          // MAIN rests while nothing else is waiting; elapsed saturates so it cannot wrap.
          if (other_demand && (max_out || (min_met && bus.main_num == 3'd0))) begin
            go = 1'b1; go_state = ST_MAIN_Y;
          end else if (!max_out) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_LEFT_G: begin
        if (emerg) begin
          go = 1'b1; go_state = ST_LEFT_Y;
        end else if (tick) begin
          if (max_out || (min_met && bus.left_num == 3'd0)) begin
            go = 1'b1; go_state = ST_LEFT_Y;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_SEC_G: begin
        // Emergency hands over to EMERG, which shows the same secondary green.
        if (emerg) begin
          go = 1'b1; go_state = ST_EMERG;
        end else if (tick) begin
          if (max_out || (min_met && bus.sec_num == 3'd0)) begin
            go = 1'b1; go_state = ST_SEC_Y;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_PED_WALK: begin
        if (emerg) begin
          go = 1'b1; go_state = ST_PED_FLASH;
        end else if (tick) begin
          if (timer_done) begin
            go = 1'b1; go_state = ST_PED_FLASH;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_MAIN_Y, ST_LEFT_Y, ST_SEC_Y, ST_PED_FLASH: begin
        if (tick) begin
          if (timer_done) begin
            go = 1'b1; go_state = ST_ALL_RED;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_ALL_RED: begin
        if (tick) begin
          if (timer_done) begin
            go = 1'b1;
            if (emerg) begin
              go_state = ST_EMERG;
            end else begin
              go_state = green_of(next_phase);
              ptr_d    = next_phase;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_EMERG: begin
        // Clearing an emergency counts as having served the secondary road.
        if (!emerg) begin
          go = 1'b1; go_state = ST_SEC_Y;
          ptr_d = PH_SEC;
        end
      end
      default: begin
        go = 1'b1; go_state = ST_ALL_RED;
      end
    endcase

    if (go) begin
      state_d = go_state;
      cnt_d   = entry_count(go_state);
    end
  end

  // State, counter, pointer and prescaler registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_ALL_RED;
      cnt_q   <= 8'(ALLRED_T);
      ptr_q   <= PH_PED;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      presc_q <= presc_d;
    end
  end

  // Lamp decode straight from the registered state.
  always_comb begin
    bus.m_LRYG = 4'b0100;
    bus.s_RYG  = 3'b100;
    bus.p      = 3'b100;
    case (state_q)
      ST_MAIN_G:    bus.m_LRYG = 4'b0001;
      ST_MAIN_Y:    bus.m_LRYG = 4'b0010;
      ST_LEFT_G:    bus.m_LRYG = 4'b1100;
      ST_LEFT_Y:    bus.m_LRYG = 4'b0010;
      ST_SEC_G:     bus.s_RYG  = 3'b001;
      ST_SEC_Y:     bus.s_RYG  = 3'b010;
      ST_PED_WALK:  bus.p      = 3'b001;
      ST_PED_FLASH: bus.p      = 3'b010;
      ST_EMERG:     bus.s_RYG  = 3'b001;
      default: ;
    endcase
  end

  assign bus.state_o = state_q;

endmodule
